// File: rtl/adc_5g_phase_cal.sv
// Sampling-phase calibration for the 5 GS/s ADC interface: sweeps the DCM phase,
// scores every position against a static test pattern and parks on the widest clean window.

module adc_5g_phase_cal_lane #(
   parameter int VEC_W = 8
) (
   input  logic [VEC_W-1:0] data_i,
   input  logic [VEC_W-1:0] pattern_i,
   output logic             mismatch_o
);
   assign mismatch_o = (data_i != pattern_i);
endmodule

module adc_5g_phase_cal #(
   parameter int N_STEPS    = 64,
   parameter int SETTLE_CYC = 64,
   parameter int CHECK_CYC  = 256,
   parameter int PS_TIMEOUT = 1023
) (
   input  logic       dcm_psclk_i,
   input  logic       ctrl_reset_i,
   input  logic       cal_start_i,
   input  logic [7:0] cal_pattern_i,
   input  logic [7:0] user_datai0_i,
   input  logic [7:0] user_datai1_i,
   input  logic [7:0] user_datai2_i,
   input  logic [7:0] user_datai3_i,
   input  logic [7:0] user_dataq0_i,
   input  logic [7:0] user_dataq1_i,
   input  logic [7:0] user_dataq2_i,
   input  logic [7:0] user_dataq3_i,
   input  logic       user_data_valid_i,
   output logic       dcm_psen_o,
   output logic       dcm_psincdec_o,
   input  logic       dcm_psdone_i,
   output logic       cal_busy_o,
   output logic       cal_done_o,
   output logic       cal_fail_o,
   output logic [7:0] cal_center_o,
   output logic [7:0] cal_width_o,
   output logic [7:0] cal_pos_o
);
   localparam int NUM_LANES = 8;
   localparam int VEC_W     = 8;
   localparam int CNT_MAX0  = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
   localparam int CNT_MAX   = (CNT_MAX0 > PS_TIMEOUT) ? CNT_MAX0 : PS_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(PS_TIMEOUT - 1);
   localparam logic [8:0]       POS_LAST    = 9'(N_STEPS);

   typedef enum logic [3:0] {
      S_IDLE, S_SETTLE, S_CHECK, S_EVAL, S_SHIFT, S_WAIT_DONE,
      S_RET_SHIFT, S_RET_WAIT, S_DONE, S_FAIL
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [8:0]       pos_q, pos_d;
   logic [8:0]       cur_len_q, cur_len_d;
   logic [8:0]       cur_start_q, cur_start_d;
   logic [8:0]       best_len_q, best_len_d;
   logic [8:0]       best_start_q, best_start_d;
   logic [8:0]       target_q, target_d;
   logic             fail_pend_q, fail_pend_d;
   logic             incdec_q, incdec_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fail_q, fail_d;
   logic [7:0]       center_q, center_d;
   logic [7:0]       width_q, width_d;

   logic [NUM_LANES-1:0][VEC_W-1:0] lane_data;
   logic [NUM_LANES-1:0]            lane_err;

   assign lane_data = {user_dataq3_i, user_dataq2_i, user_dataq1_i, user_dataq0_i,
                       user_datai3_i, user_datai2_i, user_datai1_i, user_datai0_i};

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         adc_5g_phase_cal_lane #(.VEC_W(VEC_W)) u_lane (
            .data_i     (lane_data[g]),
            .pattern_i  (cal_pattern_i),
            .mismatch_o (lane_err[g])
         );
      end
   endgenerate

   function automatic logic [7:0] sat8(input logic [8:0] v);
      return v[8] ? 8'hFF : v[7:0];
   endfunction

   // Window trackers as they will stand after the current EVAL cycle.
   logic [8:0] ev_len, ev_start, ev_best_len, ev_best_start, ev_target;
   logic       ev_none;

   always_comb begin
      ev_len        = '0;
      ev_start      = cur_start_q;
      ev_best_len   = best_len_q;
      ev_best_start = best_start_q;
      if (!err_q) begin
         ev_len = cur_len_q + 9'd1;
         if (cur_len_q == '0) ev_start = pos_q;
         if (ev_len > best_len_q) begin
            ev_best_len   = ev_len;
            ev_best_start = ev_start;
         end
      end
      ev_none   = (ev_best_len == '0);
      ev_target = ev_none ? 9'd0 : ev_best_start + ((ev_best_len - 9'd1) >> 1);
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      pos_d        = pos_q;
      cur_len_d    = cur_len_q;
      cur_start_d  = cur_start_q;
      best_len_d   = best_len_q;
      best_start_d = best_start_q;
      target_d     = target_q;
      fail_pend_d  = fail_pend_q;
      incdec_d     = incdec_q;
      busy_d       = busy_q;
      done_d       = done_q;
      fail_d       = fail_q;
      center_d     = center_q;
      width_d      = width_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (cal_start_i) begin
               done_d       = 1'b0;
               fail_d       = 1'b0;
               center_d     = '0;
               width_d      = '0;
               cur_len_d    = '0;
               cur_start_d  = '0;
               best_len_d   = '0;
               best_start_d = '0;
               target_d     = '0;
               fail_pend_d  = 1'b0;
               pos_d        = '0;
               cnt_d        = '0;
               busy_d       = 1'b1;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CHECK: begin
            // Only qualified samples advance the window or contribute errors.
            if (user_data_valid_i) begin
               err_d = err_q | (|lane_err);
               if (cnt_q == CHECK_LAST) begin
                  cnt_d   = '0;
                  state_d = S_EVAL;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_EVAL: begin
            cur_len_d    = ev_len;
            cur_start_d  = ev_start;
            best_len_d   = ev_best_len;
            best_start_d = ev_best_start;
            if (pos_q == POS_LAST) begin
               target_d    = ev_target;
               fail_pend_d = ev_none;
               if (pos_q == ev_target) begin
                  busy_d = 1'b0;
                  width_d = sat8(ev_best_len);
                  if (ev_none) begin
                     fail_d  = 1'b1;
                     state_d = S_FAIL;
                  end else begin
                     done_d   = 1'b1;
                     center_d = ev_target[7:0];
                     state_d  = S_DONE;
                  end
               end else begin
                  incdec_d = 1'b0;
                  state_d  = S_RET_SHIFT;
               end
            end else begin
               incdec_d = 1'b1;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            cnt_d   = '0;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (dcm_psdone_i) begin
               pos_d   = pos_q + 9'd1;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end else if (cnt_q == TO_LAST) begin
               busy_d  = 1'b0;
               fail_d  = 1'b1;
               width_d = sat8(best_len_q);
               state_d = S_FAIL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RET_SHIFT: begin
            cnt_d   = '0;
            state_d = S_RET_WAIT;
         end
         S_RET_WAIT: begin
            if (dcm_psdone_i) begin
               pos_d = pos_q - 9'd1;
               if ((pos_q - 9'd1) == target_q) begin
                  busy_d  = 1'b0;
                  width_d = sat8(best_len_q);
                  if (fail_pend_q) begin
                     fail_d  = 1'b1;
                     state_d = S_FAIL;
                  end else begin
                     done_d   = 1'b1;
                     center_d = target_q[7:0];
                     state_d  = S_DONE;
                  end
               end else begin
                  state_d = S_RET_SHIFT;
               end
            end else if (cnt_q == TO_LAST) begin
               busy_d  = 1'b0;
               fail_d  = 1'b1;
               width_d = sat8(best_len_q);
               state_d = S_FAIL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge dcm_psclk_i) begin
      if (ctrl_reset_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         pos_q        <= '0;
         cur_len_q    <= '0;
         cur_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
         target_q     <= '0;
         fail_pend_q  <= 1'b0;
         incdec_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         center_q     <= '0;
         width_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         pos_q        <= pos_d;
         cur_len_q    <= cur_len_d;
         cur_start_q  <= cur_start_d;
         best_len_q   <= best_len_d;
         best_start_q <= best_start_d;
         target_q     <= target_d;
         fail_pend_q  <= fail_pend_d;
         incdec_q     <= incdec_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         center_q     <= center_d;
         width_q      <= width_d;
      end
   end

   assign dcm_psen_o     = (state_q == S_SHIFT) || (state_q == S_RET_SHIFT);
   assign dcm_psincdec_o = incdec_q;
   assign cal_busy_o     = busy_q;
   assign cal_done_o     = done_q;
   assign cal_fail_o     = fail_q;
   assign cal_center_o   = center_q;
   assign cal_width_o    = width_q;
   assign cal_pos_o      = pos_q[7:0];

endmodule

// File: tb/tb_adc_5g_phase_cal.sv
// Bench for adc_5g_phase_cal: a DCM/ADC model drives lanes from a per-position good mask;
// results are checked against a table of hand-derived vectors and a window-search model.

module tb_adc_5g_phase_cal;
   localparam int N   = 8;
   localparam int SET = 4;
   localparam int CHK = 8;
   localparam int TO  = 20;

   logic       clk = 1'b0;
   logic       ctrl_reset, cal_start, user_data_valid, dcm_psdone;
   logic [7:0] cal_pattern;
   logic [7:0] lane [8];
   logic       dcm_psen, dcm_psincdec, cal_busy, cal_done, cal_fail;
   logic [7:0] cal_center, cal_width, cal_pos;

   always #5 clk = ~clk;

   adc_5g_phase_cal #(.N_STEPS(N), .SETTLE_CYC(SET), .CHECK_CYC(CHK), .PS_TIMEOUT(TO)) dut (
      .dcm_psclk_i       (clk),
      .ctrl_reset_i      (ctrl_reset),
      .cal_start_i       (cal_start),
      .cal_pattern_i     (cal_pattern),
      .user_datai0_i     (lane[0]),
      .user_datai1_i     (lane[1]),
      .user_datai2_i     (lane[2]),
      .user_datai3_i     (lane[3]),
      .user_dataq0_i     (lane[4]),
      .user_dataq1_i     (lane[5]),
      .user_dataq2_i     (lane[6]),
      .user_dataq3_i     (lane[7]),
      .user_data_valid_i (user_data_valid),
      .dcm_psen_o        (dcm_psen),
      .dcm_psincdec_o    (dcm_psincdec),
      .dcm_psdone_i      (dcm_psdone),
      .cal_busy_o        (cal_busy),
      .cal_done_o        (cal_done),
      .cal_fail_o        (cal_fail),
      .cal_center_o      (cal_center),
      .cal_width_o       (cal_width),
      .cal_pos_o         (cal_pos)
   );

   // Shared between the DCM/ADC model and the test sequence.
   logic [8:0] cur_mask;
   logic [7:0] cur_pat;
   int bad_lane, base_pos, withhold_at;
   int inject_req, spur_req;
   int sweep_pos, n_psen, n_inc, n_dec, inject_ack, spur_ack, dly, step;
   int checks, failures;

   initial begin
      sweep_pos = 0; n_psen = 0; n_inc = 0; n_dec = 0;
      inject_ack = 0; spur_ack = 0; dly = 0; step = 0;
   end

   // DCM: answers each psen with one psdone after 1..4 cycles. ADC: lanes carry the
   // pattern at good positions, one corrupted lane elsewhere, garbage when not valid.
   always @(negedge clk) begin
      int rel;
      logic v;
      dcm_psdone = 1'b0;
      if (ctrl_reset) begin
         dly = 0;
      end else begin
         if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               dcm_psdone = 1'b1;
               sweep_pos += step;
            end
         end
         if (dcm_psen) begin
            n_psen++;
            if (dcm_psincdec) n_inc++; else n_dec++;
            if (n_psen != withhold_at) begin
               dly  = $urandom_range(1, 4);
               step = dcm_psincdec ? 1 : -1;
            end
         end
         if (spur_req != spur_ack) begin
            dcm_psdone = 1'b1;
            spur_ack   = spur_req;
         end
      end
      rel = sweep_pos - base_pos;
      v = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) lane[i] = cur_pat;
      if (inject_req != inject_ack) begin
         v = 1'b1;
         lane[bad_lane] = ~cur_pat;
         inject_ack = inject_req;
      end else if (!v) begin
         for (int i = 0; i < 8; i++) lane[i] = 8'($urandom);
      end else if (rel < 0 || rel > N || !cur_mask[rel]) begin
         lane[bad_lane] = cur_pat ^ (8'h01 << $urandom_range(0, 7));
      end
      user_data_valid = v;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected result from the good mask: longest run of good positions, earliest on ties.
   function automatic void model(input logic [8:0] m, output int center, output int width,
                                 output bit done, output bit fail, output int ndec, output int pos);
      int best = 0, bs = 0;
      for (int s = 0; s <= N; s++) begin
         int l = 0;
         while (s + l <= N && m[s + l]) l++;
         if (l > best) begin best = l; bs = s; end
      end
      fail   = (best == 0);
      done   = !fail;
      width  = best;
      pos    = fail ? 0 : bs + (best - 1) / 2;
      center = fail ? 0 : pos;
      ndec   = N - pos;
   endfunction

   task automatic run_case(input string nm, input logic [8:0] mask, input logic [7:0] pat,
                           input int badl, input bit one_bad, input bit restart,
                           input int e_center, input int e_width, input bit e_done,
                           input bit e_fail, input int e_inc, input int e_dec, input int e_pos);
      int c, b_inc, b_dec;
      bit fin;
      @(negedge clk);
      cur_mask = mask; cur_pat = pat; cal_pattern = pat; bad_lane = badl;
      base_pos = sweep_pos; b_inc = n_inc; b_dec = n_dec;
      cal_start = 1'b1;
      @(negedge clk);
      cal_start = 1'b0;
      if (one_bad) begin
         repeat (SET + 2) @(posedge clk);
         #2 inject_req++;
      end
      c = 0; fin = 1'b0;
      while (!fin && c < 5000) begin
         @(negedge clk);
         c++;
         cal_start = restart && (c == 40);
         if (cal_done || cal_fail) fin = 1'b1;
      end
      cal_start = 1'b0;
      chk({nm, ".finished"}, int'(fin), 1);
      chk({nm, ".done"},   int'(cal_done), int'(e_done));
      chk({nm, ".fail"},   int'(cal_fail), int'(e_fail));
      chk({nm, ".busy"},   int'(cal_busy), 0);
      chk({nm, ".center"}, int'(cal_center), e_center);
      chk({nm, ".width"},  int'(cal_width), e_width);
      chk({nm, ".pos"},    int'(cal_pos), e_pos);
      chk({nm, ".n_inc"},  n_inc - b_inc, e_inc);
      chk({nm, ".n_dec"},  n_dec - b_dec, e_dec);
   endtask

   typedef struct {
      string      nm;
      logic [8:0] mask;
      int         badl;
      bit         one_bad;
      int         center, width;
      bit         done, fail;
      int         ninc, ndec, pos;
   } vec_t;

   vec_t vt[7];

   initial begin
      int c, seen, b_ps, r_center, r_width, r_ndec, r_pos;
      bit r_done, r_fail;
      logic [8:0] m;
      checks = 0; failures = 0;
      inject_req = 0; spur_req = 0; withhold_at = -1; base_pos = 0;
      cur_mask = 9'h1FF; cur_pat = 8'hA5; bad_lane = 6;
      ctrl_reset = 1'b1; cal_start = 1'b0; cal_pattern = 8'hA5;

      vt[0] = '{"all_good",  9'h1FF, 6, 1'b0, 4, 9, 1'b1, 1'b0, 8, 4, 4};
      vt[1] = '{"q2_3to6",   9'h078, 6, 1'b0, 4, 4, 1'b1, 1'b0, 8, 4, 4};
      vt[2] = '{"tie",       9'h066, 2, 1'b0, 1, 2, 1'b1, 1'b0, 8, 7, 1};
      vt[3] = '{"one_bad",   9'h1FF, 3, 1'b1, 4, 8, 1'b1, 1'b0, 8, 4, 4};
      vt[4] = '{"none",      9'h000, 0, 1'b0, 0, 0, 1'b0, 1'b1, 8, 8, 0};
      vt[5] = '{"last_only", 9'h100, 7, 1'b0, 8, 1, 1'b1, 1'b0, 8, 0, 8};
      vt[6] = '{"first_only",9'h001, 5, 1'b0, 0, 1, 1'b1, 1'b0, 8, 8, 0};

      repeat (3) @(negedge clk);
      chk("reset.busy",   int'(cal_busy), 0);
      chk("reset.done",   int'(cal_done), 0);
      chk("reset.fail",   int'(cal_fail), 0);
      chk("reset.center", int'(cal_center), 0);
      chk("reset.width",  int'(cal_width), 0);
      chk("reset.pos",    int'(cal_pos), 0);
      chk("reset.psen",   int'(dcm_psen), 0);
      ctrl_reset = 1'b0;

      for (int i = 0; i < 7; i++)
         run_case(vt[i].nm, vt[i].mask, 8'hA5 ^ 8'(i * 17), vt[i].badl, vt[i].one_bad, i == 1,
                  vt[i].center, vt[i].width, vt[i].done, vt[i].fail,
                  vt[i].ninc, vt[i].ndec, vt[i].pos);

      // A psdone with no shift outstanding must not move the tracked position.
      run_case("pre_spur", 9'h1FF, 8'h3C, 1, 1'b0, 1'b0, 4, 9, 1'b1, 1'b0, 8, 4, 4);
      @(negedge clk);
      spur_req++;
      repeat (4) @(negedge clk);
      chk("spur.pos",  int'(cal_pos), 4);
      chk("spur.done", int'(cal_done), 1);

      for (int k = 0; k < 6; k++) begin
         m = 9'($urandom);
         model(m, r_center, r_width, r_done, r_fail, r_ndec, r_pos);
         run_case($sformatf("rand%0d", k), m, 8'($urandom), $urandom_range(0, 7), 1'b0, k[0],
                  r_center, r_width, r_done, r_fail, N, r_ndec, r_pos);
      end

      // Third increment never completes: fail after exactly TO cycles of waiting.
      @(negedge clk);
      cur_mask = 9'h1FF; base_pos = sweep_pos; b_ps = n_psen; withhold_at = n_psen + 3;
      cal_start = 1'b1;
      @(negedge clk);
      cal_start = 1'b0;
      seen = 0; c = 0;
      while (seen < 3 && c < 5000) begin
         @(negedge clk);
         c++;
         if (dcm_psen) seen++;
      end
      chk("timeout.third_psen", seen, 3);
      c = 0;
      while (!cal_fail && c < TO + 50) begin
         @(negedge clk);
         c++;
      end
      chk("timeout.latency", c - 1, TO);
      chk("timeout.fail",  int'(cal_fail), 1);
      chk("timeout.done",  int'(cal_done), 0);
      chk("timeout.busy",  int'(cal_busy), 0);
      chk("timeout.pos",   int'(cal_pos), 2);
      chk("timeout.width", int'(cal_width), 3);
      repeat (40) @(negedge clk);
      chk("timeout.no_more_psen", n_psen - b_ps, 3);
      withhold_at = -1;

      // Reset while checking position 0.
      @(negedge clk);
      base_pos = sweep_pos;
      cal_start = 1'b1;
      @(negedge clk);
      cal_start = 1'b0;
      repeat (SET + 3) @(negedge clk);
      chk("midrst.busy_before", int'(cal_busy), 1);
      ctrl_reset = 1'b1;
      @(negedge clk);
      ctrl_reset = 1'b0;
      chk("midrst.busy",    int'(cal_busy), 0);
      chk("midrst.done",    int'(cal_done), 0);
      chk("midrst.fail",    int'(cal_fail), 0);
      chk("midrst.center",  int'(cal_center), 0);
      chk("midrst.width",   int'(cal_width), 0);
      chk("midrst.pos",     int'(cal_pos), 0);
      chk("midrst.psen",    int'(dcm_psen), 0);
      chk("midrst.incdec",  int'(dcm_psincdec), 0);
      b_ps = n_psen;
      repeat (20) @(negedge clk);
      chk("midrst.idle_no_psen", n_psen - b_ps, 0);
      chk("midrst.idle_busy", int'(cal_busy), 0);

      run_case("after_rst", 9'h078, 8'h5A, 6, 1'b0, 1'b0, 4, 4, 1'b1, 1'b0, 8, 4, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
